com_to_in: RTL and testbench

Serial receiver for the PC link. It is the inbound counterpart of the byte transmitter: it samples the `rx` line, recovers frames of start(0), 8 data bits LSB first, even parity (parity bit = XOR of the data bits) and stop(1), and checks each frame. Each received byte is held in an output register behind a valid/ack handshake until the consuming logic takes it.

---
 rtl/com_pkg.sv | 23 ++
 rtl/com_to_in_if.sv | 39 +++
 rtl/com_rx_sampler.sv | 55 +++++
 rtl/com_to_in.sv | 208 ++++++++++++++++++++
 tb/tb_com_to_in.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/com_pkg.sv
// Shared definitions for the PC-link serial blocks (receiver and transmitter).
// Holds the receiver state encoding, frame geometry constants and the parity
// helper, so both directions agree on what even parity means.
package com_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } com_state_t;

    localparam int COM_DATA_BITS      = 8;
    localparam int COM_OVERSAMPLE_DEF = 16;

    // Even parity: the parity bit equals the XOR of all data bits.
    function automatic logic com_parity(input logic [COM_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/com_to_in_if.sv
// Byte handoff between the serial receiver and its consumer.
//
// Handshake: `valid` high means `data`/`parity_err` hold a byte that has not
// been taken yet; they stay stable while `valid` is high.  The consumer
// raises `ack` for a cycle to take it, and `valid` drops on the following
// edge unless a new byte lands on that same edge.  `ack` with `valid` low has
// no effect.  `overrun` is sticky until the next `ack`; `frame_err` is a
// one-cycle event pulse that is not part of the handshake.
interface com_to_in_if;
    import com_pkg::*;

    logic [COM_DATA_BITS-1:0] data;
    logic                     valid;
    logic                     ack;
    logic                     parity_err;
    logic                     overrun;
    logic                     frame_err;

    // Receiver side.
    modport master (
        output data,
        output valid,
        output parity_err,
        output overrun,
        output frame_err,
        input  ack
    );

    // Consumer side.
    modport slave (
        input  data,
        input  valid,
        input  parity_err,
        input  overrun,
        input  frame_err,
        output ack
    );

endinterface

// File: rtl/com_rx_sampler.sv
// Line front end for the serial receiver.
// Brings the asynchronous `rx` line into the clock domain through a 2-flop
// synchronizer (reset to the idle level 1) and produces the bit decision
// value used by the frame state machine.
// Build option COM_RX_MAJORITY_EN: the decision becomes the majority of the
// last three synchronized samples taken on enable ticks (the current one
// included), which rejects a single-tick glitch.  Without it the decision is
// the current synchronized sample.
module com_rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic rx,
    output logic rxs,
    output logic rx_bit
);

    logic [1:0] sync_q;

    // Two-stage synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxs = sync_q[1];

`ifdef COM_RX_MAJORITY_EN
    // The two previous tick samples; the third vote is the live rxs value.
    logic [1:0] hist_q;

    // Shift history only on oversample ticks so it spans three ticks, not clks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else if (enable) begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign rx_bit = (hist_q[1] & hist_q[0]) |
                    (hist_q[1] & rxs)       |
                    (hist_q[0] & rxs);
`else
    // Tick qualification is not needed when deciding on a single sample.
    logic unused_enable;
    assign unused_enable = enable;

    assign rx_bit = rxs;
`endif

endmodule

// File: rtl/com_to_in.sv
// com_to_in: serial receiver for the PC link.
// Recovers frames of start(0), 8 data bits LSB first, even parity and
// stop(1) from `rx`, sampling only on `enable` ticks (OVERSAMPLE per bit).
// A good frame is held in an output register behind the valid/ack handshake
// of com_to_in_if; a bad stop bit pulses frame_err and discards the byte; a
// byte arriving while the previous one is still unacknowledged is dropped and
// sets the sticky overrun flag.
// Build option COM_RX_MAJORITY_EN selects 3-sample majority bit decisions in
// com_rx_sampler; frame timing is the same in both builds.
// OVERSAMPLE must be even and at least 4.
module com_to_in
    import com_pkg::*;
#(
    parameter int OVERSAMPLE = COM_OVERSAMPLE_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          rx,
    com_to_in_if.master   bus,
    output logic          busy,
    output com_state_t    state_dbg
);

    localparam int TW = $clog2(OVERSAMPLE);

    // Start bit is judged half a bit in; every later bit one full bit later,
    // which lands each decision near the middle of its bit cell.
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(COM_DATA_BITS - 1);

    logic rxs;
    logic rx_bit;

    com_rx_sampler u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .rx     (rx),
        .rxs    (rxs),
        .rx_bit (rx_bit)
    );

    // Frame tracking state.
    com_state_t               state_q, state_d;
    logic [TW-1:0]            tick_q, tick_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [COM_DATA_BITS-1:0] shift_q, shift_d;
    logic                     perr_q, perr_d;
    logic                     armed_q, armed_d;

    // Stop-bit outcome on the decision tick.
    logic stop_good;
    logic stop_bad;

    // Output holding register.
    logic [COM_DATA_BITS-1:0] data_q;
    logic                     valid_q;
    logic                     parity_err_q;
    logic                     overrun_q;
    logic                     frame_err_q;

    // Frame state and counters advance together; everything freezes without enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            armed_q   <= armed_d;
        end
    end

    // Next-state logic: one decision per bit cell, taken on the tick where
    // the cell counter reaches its decision point.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        armed_d   = armed_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    // Only a high-to-low transition starts a frame, so a line
                    // stuck low after a framing error stays ignored.
                    if (rxs) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end

                START: begin
                    if (tick_q == HALF_LAST) begin
                        if (!rx_bit) begin
                            state_d   = DATA;
                            tick_d    = '0;
                            bit_idx_d = '0;
                        end else begin
                            // Line went back high: noise, not a start bit.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end

                DATA: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d            = '0;
                        shift_d[bit_idx_q] = rx_bit;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = PARITY;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end

                PARITY: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        perr_d  = rx_bit ^ com_parity(shift_q);
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end

                STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        armed_d = 1'b0;
                        if (rx_bit) begin
                            stop_good = 1'b1;
                        end else begin
                            stop_bad = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output register and handshake; ack is serviced every clk regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            if (stop_good && (!valid_q || bus.ack)) begin
                // New byte lands; a same-edge ack retires the old one and
                // its overrun history with it.
                data_q       <= shift_q;
                parity_err_q <= perr_q;
                valid_q      <= 1'b1;
                if (valid_q) begin
                    overrun_q <= 1'b0;
                end
            end else if (stop_good) begin
                // Previous byte still pending: keep it, drop the new one.
                overrun_q <= 1'b1;
            end else if (valid_q && bus.ack) begin
                valid_q      <= 1'b0;
                parity_err_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_com_to_in.sv
// Bench for com_to_in: OVERSAMPLE=16, enable tied high, rx driven at the
// falling clock edge and outputs sampled at the falling clock edge.
module tb_com_to_in;
    import com_pkg::*;

    localparam int OS = 16;

    // ---------------- clock / reset ----------------
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b1;
    logic       rx     = 1'b1;
    logic       busy;
    com_state_t state_dbg;

    com_to_in_if bus ();

    com_to_in #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rx        (rx),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks    = 0;
    int         n_errors    = 0;
    int         ferr_cycles = 0;
    logic       valid_prev  = 1'b0;
    logic [8:0] exp_q[$];      // {parity_err, data}
    logic [8:0] exp_e;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full frame; glitch >= 0 inverts rx for the single clk at that offset.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch);
        logic [10:0] bits;
        int c;
        bits = {stop, par, d, 1'b0};
        c = 0;
        for (int b = 0; b < 11; b++) begin
            for (int t = 0; t < OS; t++) begin
                @(negedge clk);
                rx = bits[b] ^ (c == glitch);
                c++;
            end
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(bus.valid), 32'd0);
        check({tag, "_overrun_after_ack"}, 32'(bus.overrun), 32'd0);
        check({tag, "_perr_after_ack"}, 32'(bus.parity_err), 32'd0);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (bus.frame_err) ferr_cycles++;
        if (bus.valid && !valid_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_byte: got data 0x%0h, expected no byte", bus.data);
            end else begin
                exp_e = exp_q.pop_front();
                check("rx_data", 32'(bus.data), 32'(exp_e[7:0]));
                check("rx_parity_err", 32'(bus.parity_err), 32'(exp_e[8]));
            end
        end
        valid_prev = bus.valid;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        bus.ack = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 8'h01, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};
        for (int i = 6; i < 8; i++) begin
            vecs[i].d        = 8'($urandom_range(0, 255));
            vecs[i].par      = 1'($urandom_range(0, 1));
            vecs[i].exp_data = vecs[i].d;
            vecs[i].exp_perr = vecs[i].par ^ (^vecs[i].d);
        end

        // Reset values.
        idle(3);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        idle(8);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Table of clean-stop frames.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].exp_perr, vecs[i].exp_data});
            send_frame(vecs[i].d, vecs[i].par, 1'b1, -1);
            check("vec_valid", 32'(bus.valid), 32'd1);
            check("vec_busy", 32'(busy), 32'd0);
            check("vec_state", 32'(state_dbg), 32'(IDLE));
            do_ack("vec");
            idle(2);
        end

        // False start: 4 clks low, then back high.
        rx = 1'b0;
        idle(4);
        check("fs_state_start", 32'(state_dbg), 32'(START));
        check("fs_busy_high", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(20);
        check("fs_state_idle", 32'(state_dbg), 32'(IDLE));
        check("fs_busy_low", 32'(busy), 32'd0);
        check("fs_valid", 32'(bus.valid), 32'd0);

        // Frame error, then line held low, then a good frame.
        ferr_cycles = 0;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        rx = 1'b0;
        check("fe_pulse_cycles", 32'(ferr_cycles), 32'd1);
        check("fe_valid", 32'(bus.valid), 32'd0);
        idle(40);
        check("fe_low_state", 32'(state_dbg), 32'(IDLE));
        check("fe_low_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        idle(16);
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1'b0, 1'b1, -1);
        check("fe_next_valid", 32'(bus.valid), 32'd1);
        check("fe_next_data", 32'(bus.data), 32'h55);
        check("fe_total_pulses", 32'(ferr_cycles), 32'd1);
        do_ack("fe");
        idle(2);

        // Overrun: second byte arrives with the first still pending.
        exp_q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b0, 1'b1, -1);
        idle(4);
        send_frame(8'h22, 1'b0, 1'b1, -1);
        check("ovr_valid", 32'(bus.valid), 32'd1);
        check("ovr_data", 32'(bus.data), 32'h11);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        do_ack("ovr");
        idle(2);

        // Reset in the middle of data bit 4 with a byte pending.
        exp_q.push_back({1'b0, 8'h99});
        send_frame(8'h99, 1'b0, 1'b1, -1);
        check("mr_pending_valid", 32'(bus.valid), 32'd1);
        fork
            send_frame(8'hC3, 1'b0, 1'b1, -1);
            begin
                idle(88);
                check("mr_busy_before", 32'(busy), 32'd1);
                rst_n = 1'b0;
                #1;
                check("mr_data", 32'(bus.data), 32'd0);
                check("mr_valid", 32'(bus.valid), 32'd0);
                check("mr_parity_err", 32'(bus.parity_err), 32'd0);
                check("mr_overrun", 32'(bus.overrun), 32'd0);
                check("mr_frame_err", 32'(bus.frame_err), 32'd0);
                check("mr_busy", 32'(busy), 32'd0);
                check("mr_state", 32'(state_dbg), 32'(IDLE));
            end
        join
        idle(10);
        rst_n = 1'b1;
        idle(10);
        exp_q.push_back({1'b0, 8'h7E});
`ifdef COM_RX_MAJORITY_EN
        send_frame(8'h7E, 1'b0, 1'b1, 72);
`else
        send_frame(8'h7E, 1'b0, 1'b1, -1);
`endif
        check("mr_next_valid", 32'(bus.valid), 32'd1);
        check("mr_next_data", 32'(bus.data), 32'h7E);
        do_ack("mr");
        idle(4);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
